// File: rtl/ram_readout.sv
// Read-back engine for the capture RAM: walks addresses 1..wr_count, streams each
// word over valid/ready and folds every delivered word into an 8-bit MISR signature.
module ram_readout #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] wr_count,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          empty,
    output logic [DW-1:0] signature
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    // Feedback taps of x^8+x^4+x^3+x^2+1; the polynomial only exists for DW = 8.
    localparam logic [DW-1:0] POLY = DW'(8'h1D);

    state_t        state_reg, state_next;
    logic [AW-1:0] rd_addr_reg, rd_addr_next;
    logic [AW-1:0] end_addr_reg, end_addr_next;
    logic [DW-1:0] out_data_reg, out_data_next;
    logic [DW-1:0] sig_reg, sig_next;
    logic          out_valid_reg, out_valid_next;
    logic          busy_reg, busy_next;
    logic          empty_reg, empty_next;
    logic [DW-1:0] misr_val;

    // One MISR step: shift left, fold the MSB back through the taps, xor in the word.
    for (genvar gi = 0; gi < DW; gi++) begin : g_misr
        if (gi == 0) begin : g_lsb
            assign misr_val[gi] = (sig_reg[DW-1] & POLY[gi]) ^ out_data_reg[gi];
        end else begin : g_bit
            assign misr_val[gi] = sig_reg[gi-1] ^ (sig_reg[DW-1] & POLY[gi]) ^ out_data_reg[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            end_addr_reg  <= '0;
            out_data_reg  <= '0;
            sig_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            empty_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            end_addr_reg  <= end_addr_next;
            out_data_reg  <= out_data_next;
            sig_reg       <= sig_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            empty_reg     <= empty_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        end_addr_next  = end_addr_reg;
        out_data_next  = out_data_reg;
        sig_next       = sig_reg;
        out_valid_next = out_valid_reg;
        busy_next      = busy_reg;
        empty_next     = empty_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    sig_next = '0;
                    if (wr_count != '0) begin
                        end_addr_next = wr_count;
                        rd_addr_next  = AW'(1);
                        empty_next    = 1'b0;
                        busy_next     = 1'b1;
                        state_next    = FETCH;
                    end else begin
                        empty_next = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            FETCH: begin
                out_data_next  = rd_data;
                out_valid_next = 1'b1;
                state_next     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    sig_next       = misr_val;
                    // end_addr bounds the walk, so rd_addr never wraps back to 0.
                    if (rd_addr_reg == end_addr_reg) begin
                        busy_next  = 1'b0;
                        state_next = DONE;
                    end else begin
                        rd_addr_next = rd_addr_reg + AW'(1);
                        state_next   = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_addr   = rd_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = (state_reg == DONE);
    assign empty     = empty_reg;
    assign signature = sig_reg;

endmodule

// File: tb/tb_ram_readout.sv
// Directed bench for ram_readout: a RAM model feeds rd_data, expected words are
// queued at start and popped on each handshake, signatures come from a MISR model.
module tb_ram_readout;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] wr_count;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       empty;
    logic [7:0] signature;

    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] exp_sig;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sig_plain;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    ram_readout #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .empty     (empty),
        .signature (signature)
    );

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_empty"}, 32'(empty), 0);
        chk({tag, "_signature"}, 32'(signature), 0);
    endtask

    // Runs one readout of n words. stall_word/stall_len hold out_ready low across
    // that word; poke pulses start and moves wr_count mid-run; abort_word resets
    // the DUT in the SEND cycle of that word.
    task automatic run(input string tag, input int n, input int stall_word, input int stall_len,
                       input bit poke, input int abort_word, input int exp_cycles);
        int  words      = 0;
        int  stall_left = stall_len;
        int  cyc        = 0;
        int  done_cyc   = -1;
        bit  got_done   = 1'b0;
        bit  aborted    = 1'b0;
        logic [7:0] got;

        exp_sig = 8'h00;
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(mem[i]);
            exp_sig = misr(exp_sig, mem[i]);
        end
        wr_count  = 8'(n);
        start     = 1'b1;
        out_ready = (stall_word == 1 && stall_len > 0) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        while (!got_done && !aborted && cyc < 2000) begin
            cyc++;
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                chk({tag, "_signature"}, 32'(signature), 32'(exp_sig));
                chk({tag, "_busy_at_done"}, 32'(busy), 0);
                chk({tag, "_empty"}, 32'(empty), (n == 0) ? 1 : 0);
            end else if (out_valid && abort_word == words + 1) begin
                #3 rst_n = 1'b0;
                #1 chk_reset_outputs({tag, "_abort"});
                aborted = 1'b1;
            end else if (out_valid) begin
                chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(words + 1));
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_word"}, 32'(out_data), 32'hFFFF_FFFF);
                end else if (out_ready) begin
                    got = exp_q.pop_front();
                    chk({tag, "_word"}, 32'(out_data), 32'(got));
                    words++;
                end else begin
                    chk({tag, "_stall_data"}, 32'(out_data), 32'(exp_q[0]));
                    stall_left--;
                end
            end
            if (!aborted) begin
                @(posedge clk);
                #1;
                out_ready = (words + 1 == stall_word && stall_left > 0) ? 1'b0 : 1'b1;
                if (poke) begin
                    start    = cyc[0];
                    wr_count = 8'd3;
                end
            end
        end
        start = 1'b0;

        if (aborted) begin
            exp_q.delete();
        end else begin
            chk({tag, "_done_seen"}, 32'(got_done), 1);
            chk({tag, "_word_count"}, 32'(words), 32'(n));
            if (exp_cycles >= 0)
                chk({tag, "_done_latency"}, 32'(done_cyc), 32'(exp_cycles));
            @(negedge clk);
            chk({tag, "_idle_after"}, 32'({busy, out_valid, done}), 0);
            chk({tag, "_sig_held"}, 32'(signature), 32'(exp_sig));
        end
        $display("%s: %0d of %0d words, signature 0x%0h, done at cycle %0d", tag, words, n, signature, done_cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        wr_count  = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        #2 chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("empty", 0, 0, 0, 1'b0, 0, 1);
        chk("empty_rd_addr", 32'(rd_addr), 0);

        mem[1] = 8'h5A;
        run("single", 1, 0, 0, 1'b0, 0, 3);

        mem[1] = 8'h01; mem[2] = 8'h02;
        run("two", 2, 0, 0, 1'b0, 0, 5);
        chk("two_sig_const", 32'(signature), 32'h00);

        mem[1] = 8'h80; mem[2] = 8'h00;
        run("feedback", 2, 0, 0, 1'b0, 0, 5);
        chk("feedback_sig_const", 32'(signature), 32'h1D);

        mem[1] = 8'hC3; mem[2] = 8'h7E; mem[3] = 8'h91;
        run("three", 3, 0, 0, 1'b0, 0, 7);
        sig_plain = signature;
        run("stalled", 3, 2, 5, 1'b0, 0, 12);
        chk("stalled_vs_plain", 32'(signature), 32'(sig_plain));

        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'hEE;
        run("full", 255, 0, 0, 1'b1, 0, 511);

        run("abort", 255, 0, 0, 1'b0, 3, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("after_abort", 255, 0, 0, 1'b0, 0, 511);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
